debug_request_sequencer: RTL and testbench
==========================================

// Module: debug_request_sequencer
// PURPOSE
//  Sequences the debug unit's per-resource controllers during a register/memory dump.
//  On a start pulse it drives each CONTROLLER_ID in turn onto the shared 6-bit request bus.
//  It captures the frames the selected controller emits while that controller signals
//  writing, then forwards them to the serial TX interface over a valid/ready handshake.
//  Sits between the debug controllers and the UART TX framer.
// PARAMETERS
//  NB_CONTROL_FRAME  32        frame width from controllers / to TX
//  N_CONTROLLERS     4         number of controllers polled, 1..63
//  FIRST_ID          6'b000000 ID of first controller; IDs are FIRST_ID..FIRST_ID+N_CONTROLLERS-1
//  IDLE_ID           6'b111111 bus value when no controller is selected; must not fall in ID range
//  BUF_DEPTH         4         frames buffered per controller, power of 2, >=1
//  TIMEOUT           16        cycles to wait for i_writing before skipping a controller
// PORTS
//  i_clock          in   1                 single clock, rising edge
//  i_reset          in   1                 asynchronous, active-low reset
//  i_dump_start     in   1                 start pulse; ignored while o_busy=1
//  i_writing        in   1                 OR of all controllers' writing outputs
//  i_frame          in   NB_CONTROL_FRAME  OR/mux of controllers' frame outputs
//  i_tx_ready       in   1                 TX accepts o_tx_data this cycle
//  o_request_select out  6                 ID driven to the controllers
//  o_tx_data        out  NB_CONTROL_FRAME  frame to TX
//  o_tx_valid       out  1                 o_tx_data valid
//  o_busy           out  1                 dump in progress (state != IDLE)
//  o_done           out  1                 1-cycle pulse when dump finishes
//  o_timeout_flag   out  1                 sticky: a controller timed out this dump
//  o_overflow_flag  out  1                 sticky: a controller sent more than BUF_DEPTH frames
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE, o_request_select=IDLE_ID, o_tx_valid=0, o_tx_data=0,
//   o_busy=0, o_done=0, both flags=0, pointers/counters=0. All outputs are registered.
//  FSM states: IDLE, SELECT, COLLECT, SEND, NEXT, DONE.
//  IDLE: select=IDLE_ID. On i_dump_start -> SELECT, cur_id=FIRST_ID, flags cleared, buffer emptied.
//  SELECT: select=cur_id; timeout counter increments each cycle.
//   - i_writing=1 -> COLLECT; frame of that cycle is written to buf[0].
//   - counter reaches TIMEOUT first -> o_timeout_flag=1, -> NEXT (no SEND).
//  COLLECT: select=cur_id; each cycle i_writing=1, i_frame is written at wr_ptr, wr_ptr++.
//   - Write with wr_ptr==BUF_DEPTH: frame dropped, o_overflow_flag=1.
//   - i_writing=0 -> SEND; select=IDLE_ID from this cycle on.
//  SEND: select=IDLE_ID; o_tx_valid=1 with o_tx_data=buf[rd_ptr].
//   - valid&ready: rd_ptr++. Data/valid hold stable until ready.
//   - After the last frame is accepted (rd_ptr==wr_ptr): valid=0 next cycle, -> NEXT.
//  NEXT: select=IDLE_ID for exactly 1 cycle, pointers and timeout counter cleared.
//   This guarantees a fresh rising match at the controllers.
//   - cur_id==FIRST_ID+N_CONTROLLERS-1 -> DONE; else cur_id++ -> SELECT.
//  DONE: o_done=1 for one cycle -> IDLE. Flags keep their value until the next i_dump_start.
//  cur_id is 6 bits; it never wraps because the range excludes IDLE_ID.
//  i_writing high in IDLE/SEND/NEXT is ignored; nothing is written.
//  i_tx_ready outside SEND is ignored.
//  i_dump_start coincident with DONE is ignored; it is accepted only in IDLE.
//  Reset mid-dump aborts immediately to reset values; the partial buffer is discarded.
//  Latency: start -> first select = 1 cycle; select change is visible on the cycle after the transition.
// TESTING
//  1. N=4, each controller writes 1 frame (0xA0+id) 2 cycles after select, ready=1
//     -> TX sees A0,A1,A2,A3 in order; select sequence 0,IDLE,1,IDLE,2,IDLE,3,IDLE; o_done once; flags 0.
//  2. Controller 2 never raises i_writing -> after 16 cycles skip to ID 3, o_timeout_flag=1,
//     TX sees 3 frames, o_done.
//  3. Controller 1 writes 6 frames with BUF_DEPTH=4 -> first 4 forwarded, 2 dropped, o_overflow_flag=1.
//  4. i_tx_ready toggles 0,0,1 repeatedly -> o_tx_data stable while valid&~ready; no frame lost or duplicated.
//  5. Reset asserted during COLLECT of ID 1 -> all outputs at reset values asynchronously;
//     new start restarts at ID 0.
//  6. i_dump_start pulsed while busy and on the DONE cycle -> ignored; exactly one o_done per accepted start.

Source files
------------

// File: rtl/debug_request_sequencer.sv
// Walks the debug controllers in ID order, buffers each controller's burst of frames
// and forwards the burst to the TX framer over a valid/ready handshake.
module debug_request_sequencer #(
  parameter int         NB_CONTROL_FRAME = 32,
  parameter int         N_CONTROLLERS    = 4,
  parameter logic [5:0] FIRST_ID         = 6'b000000,
  parameter logic [5:0] IDLE_ID          = 6'b111111,
  parameter int         BUF_DEPTH        = 4,
  parameter int         TIMEOUT          = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_dump_start,
  input  logic                        i_writing,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame,
  input  logic                        i_tx_ready,
  output logic [5:0]                  o_request_select,
  output logic [NB_CONTROL_FRAME-1:0] o_tx_data,
  output logic                        o_tx_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout_flag,
  output logic                        o_overflow_flag
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    LAST_ID  = 6'(int'(FIRST_ID) + N_CONTROLLERS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_FULL = PW'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_COLLECT,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                      state_reg;
  logic [5:0]                  cur_id_reg;
  logic [5:0]                  select_reg;
  logic [PW-1:0]               wr_ptr_reg;
  logic [PW-1:0]               rd_ptr_reg;
  logic [PW-1:0]               rd_next;
  logic [TW-1:0]               tmo_cnt_reg;
  logic [NB_CONTROL_FRAME-1:0] tx_data_reg;
  logic                        tx_valid_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic                        timeout_flag_reg;
  logic                        overflow_flag_reg;

  logic [NB_CONTROL_FRAME-1:0] buf_mem [BUF_DEPTH];
  logic                        mem_we;
  logic [AW-1:0]               mem_addr;

  assign rd_next = rd_ptr_reg + 1'b1;

  // The first frame of a burst arrives in SELECT and always lands in slot 0.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_ptr_reg[AW-1:0];
    if (state_reg == S_SELECT && i_writing) begin
      mem_we   = 1'b1;
      mem_addr = '0;
    end else if (state_reg == S_COLLECT && i_writing && wr_ptr_reg != PTR_FULL) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      buf_mem[mem_addr] <= i_frame;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg         <= S_IDLE;
      cur_id_reg        <= FIRST_ID;
      select_reg        <= IDLE_ID;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      tmo_cnt_reg       <= '0;
      tx_data_reg       <= '0;
      tx_valid_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      timeout_flag_reg  <= 1'b0;
      overflow_flag_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_dump_start) begin
            state_reg         <= S_SELECT;
            cur_id_reg        <= FIRST_ID;
            select_reg        <= FIRST_ID;
            busy_reg          <= 1'b1;
            timeout_flag_reg  <= 1'b0;
            overflow_flag_reg <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            tmo_cnt_reg       <= '0;
          end
        end
        S_SELECT: begin
          if (i_writing) begin
            state_reg  <= S_COLLECT;
            wr_ptr_reg <= PW'(1);
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout_flag_reg <= 1'b1;
            select_reg       <= IDLE_ID;
            state_reg        <= S_NEXT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        S_COLLECT: begin
          if (i_writing) begin
            if (wr_ptr_reg == PTR_FULL) begin
              overflow_flag_reg <= 1'b1;
            end else begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
          end else begin
            state_reg    <= S_SEND;
            select_reg   <= IDLE_ID;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= buf_mem[rd_ptr_reg[AW-1:0]];
          end
        end
        S_SEND: begin
          // Data holds until accepted; the next slot is fetched on the accepting edge.
          if (i_tx_ready) begin
            if (rd_next == wr_ptr_reg) begin
              tx_valid_reg <= 1'b0;
              state_reg    <= S_NEXT;
            end else begin
              rd_ptr_reg  <= rd_next;
              tx_data_reg <= buf_mem[rd_next[AW-1:0]];
            end
          end
        end
        S_NEXT: begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          tmo_cnt_reg <= '0;
          if (cur_id_reg == LAST_ID) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            cur_id_reg <= cur_id_reg + 6'd1;
            select_reg <= cur_id_reg + 6'd1;
            state_reg  <= S_SELECT;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign o_request_select = select_reg;
  assign o_tx_data        = tx_data_reg;
  assign o_tx_valid       = tx_valid_reg;
  assign o_busy           = busy_reg;
  assign o_done           = done_reg;
  assign o_timeout_flag   = timeout_flag_reg;
  assign o_overflow_flag  = overflow_flag_reg;

endmodule

// File: tb/tb_debug_request_sequencer.sv
// Randomized bench: emulated controllers answer the request bus from a per-ID plan,
// and the expected TX stream, select timeline and flags are derived from that plan.
module tb_debug_request_sequencer;

  localparam int NB     = 32;
  localparam int NC     = 4;
  localparam int BD     = 4;
  localparam int TMO    = 16;
  localparam int MAXF   = 8;
  localparam int BUDGET = 600;
  localparam logic [5:0] FID = 6'd0;
  localparam logic [5:0] IID = 6'h3F;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_dump_start;
  logic          i_writing;
  logic [NB-1:0] i_frame;
  logic          i_tx_ready;
  logic [5:0]    o_request_select;
  logic [NB-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout_flag;
  logic          o_overflow_flag;

  int errors = 0;
  int checks = 0;

  int            plan_delay [NC];
  int            plan_count [NC];
  logic [NB-1:0] plan_frame [NC][MAXF];

  always #5 i_clock = ~i_clock;

  debug_request_sequencer #(
    .NB_CONTROL_FRAME(NB),
    .N_CONTROLLERS   (NC),
    .FIRST_ID        (FID),
    .IDLE_ID         (IID),
    .BUF_DEPTH       (BD),
    .TIMEOUT         (TMO)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_dump_start    (i_dump_start),
    .i_writing       (i_writing),
    .i_frame         (i_frame),
    .i_tx_ready      (i_tx_ready),
    .o_request_select(o_request_select),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_timeout_flag  (o_timeout_flag),
    .o_overflow_flag (o_overflow_flag)
  );

  // Controller c waits d cycles after first seeing its ID, then writes k frames (k=0: silent).
  task automatic set_plan(input int c, input int d, input int k, input logic [NB-1:0] base);
    plan_delay[c] = d;
    plan_count[c] = k;
    for (int j = 0; j < MAXF; j++) plan_frame[c][j] = base + NB'(j);
  endtask

  task automatic random_plan();
    for (int c = 0; c < NC; c++)
      set_plan(c, $urandom_range(0, 12), $urandom_range(0, 6), $urandom());
  endtask

  task automatic run_dump(input int ready_mode, input bit noise, input bit start_noise,
                          input int abort_id, input string tag);
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] got_q[$];
    int            exp_val[$];
    int            exp_len[$];
    int            run_val[$];
    int            run_len[$];
    bit            exp_to, exp_ov, done_seen, prev_valid, prev_ready, rdy;
    logic [NB-1:0] prev_data;
    logic [5:0]    s, prev_s, cur_val;
    int            cur_len, sel_cyc, iter, id, m;

    exp_to = 0;
    exp_ov = 0;
    for (int c = 0; c < NC; c++) begin
      m = (plan_count[c] < BD) ? plan_count[c] : BD;
      if (plan_count[c] == 0) exp_to = 1;
      if (plan_count[c] > BD) exp_ov = 1;
      for (int j = 0; j < m; j++) exp_q.push_back(plan_frame[c][j]);
      exp_val.push_back(int'(FID) + c);
      exp_len.push_back(plan_count[c] == 0 ? TMO : plan_delay[c] + plan_count[c] + 1);
      if (c < NC - 1) begin
        exp_val.push_back(int'(IID));
        exp_len.push_back(plan_count[c] == 0 ? 1 : (ready_mode == 0 ? m + 1 : -1));
      end
    end

    @(negedge i_clock);
    i_dump_start = 1'b1;
    i_writing    = 1'b0;
    i_tx_ready   = 1'b0;
    i_frame      = '0;
    @(negedge i_clock);

    iter = 0; done_seen = 0; prev_valid = 0; prev_ready = 0; prev_data = '0;
    prev_s = IID; cur_val = IID; cur_len = 0; sel_cyc = 0;
    while (!done_seen && iter < BUDGET) begin
      s = o_request_select;
      if (iter == 0) begin
        checks++;
        if ({s, o_busy, o_timeout_flag, o_overflow_flag} !== {FID, 1'b1, 1'b0, 1'b0})
          $display("FAIL [%s] start_latency: got sel=%h busy=%b to=%b ov=%b, expected sel=%h busy=1 to=0 ov=0",
                   tag, s, o_busy, o_timeout_flag, o_overflow_flag, FID);
        if ({s, o_busy, o_timeout_flag, o_overflow_flag} !== {FID, 1'b1, 1'b0, 1'b0}) errors++;
        cur_val = s;
        cur_len = 1;
      end else if (s != cur_val) begin
        run_val.push_back(int'(cur_val));
        run_len.push_back(cur_len);
        cur_val = s;
        cur_len = 1;
      end else begin
        cur_len++;
      end
      if (s != IID && (iter == 0 || s != prev_s)) sel_cyc = 0;
      else sel_cyc++;
      prev_s = s;
      id = int'(s) - int'(FID);

      if (abort_id >= 0 && id == abort_id && sel_cyc == plan_delay[abort_id] + 2) begin
        #3 i_reset = 1'b0;
        #1;
        checks++;
        if ({o_request_select, o_tx_valid, o_tx_data, o_busy, o_done, o_timeout_flag, o_overflow_flag}
            !== {IID, 1'b0, {NB{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL [%s] async_reset: got sel=%h valid=%b data=%h busy=%b done=%b to=%b ov=%b, expected sel=%h rest 0",
                   tag, o_request_select, o_tx_valid, o_tx_data, o_busy, o_done,
                   o_timeout_flag, o_overflow_flag, IID);
        end
        i_writing    = 1'b1;
        i_dump_start = 1'b1;
        @(negedge i_clock);
        checks++;
        if ({o_request_select, o_busy, o_tx_valid} !== {IID, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL [%s] reset_hold: got sel=%h busy=%b valid=%b, expected sel=%h busy=0 valid=0",
                   tag, o_request_select, o_busy, o_tx_valid, IID);
        end
        i_reset      = 1'b1;
        i_writing    = 1'b0;
        i_dump_start = 1'b0;
        $display("[%s] reset applied during collect of id %0d", tag, abort_id);
        return;
      end

      i_writing = 1'b0;
      i_frame   = $urandom();
      if (id >= 0 && id < NC) begin
        if (sel_cyc >= plan_delay[id] && sel_cyc < plan_delay[id] + plan_count[id]) begin
          i_writing = 1'b1;
          i_frame   = plan_frame[id][sel_cyc - plan_delay[id]];
        end
      end else if (noise) begin
        i_writing = ($urandom_range(0, 1) == 1);
      end

      if (prev_valid && !prev_ready) begin
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data) begin
          errors++;
          $display("FAIL [%s] tx_hold: got valid=%b data=%h, expected valid=1 data=%h",
                   tag, o_tx_valid, o_tx_data, prev_data);
        end
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (iter % 3 == 2);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      i_tx_ready = rdy;
      if (o_tx_valid === 1'b1 && rdy) begin
        got_q.push_back(o_tx_data);
        $display("[%s] tx frame %0d data=%h", tag, got_q.size() - 1, o_tx_data);
      end
      prev_valid = (o_tx_valid === 1'b1);
      prev_ready = rdy;
      prev_data  = o_tx_data;

      if (o_done === 1'b1) begin
        done_seen    = 1;
        i_dump_start = start_noise;
      end else begin
        i_dump_start = start_noise && ($urandom_range(0, 5) == 0);
      end
      @(negedge i_clock);
      iter++;
    end

    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL [%s] done_timeout: no o_done within %0d cycles, expected one", tag, BUDGET);
      i_reset = 1'b0;
      @(negedge i_clock);
      i_reset = 1'b1;
      return;
    end

    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL [%s] post_idle: cycle %0d got busy=%b done=%b, expected busy=0 done=0",
                 tag, p, o_busy, o_done);
      end
      i_dump_start = 1'b0;
      i_writing    = 1'b0;
      i_tx_ready   = 1'b0;
      @(negedge i_clock);
    end

    checks++;
    if (o_timeout_flag !== exp_to) begin
      errors++;
      $display("FAIL [%s] timeout_flag: got %b, expected %b", tag, o_timeout_flag, exp_to);
    end
    checks++;
    if (o_overflow_flag !== exp_ov) begin
      errors++;
      $display("FAIL [%s] overflow_flag: got %b, expected %b", tag, o_overflow_flag, exp_ov);
    end

    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL [%s] frame_count: got %0d, expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL [%s] frame_%0d: got %h, expected %h", tag, i, got_q[i], exp_q[i]);
      end
    end

    checks++;
    if (run_val.size() != exp_val.size()) begin
      errors++;
      $display("FAIL [%s] select_runs: got %0d runs, expected %0d", tag, run_val.size(), exp_val.size());
    end
    for (int i = 0; i < run_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (run_val[i] != exp_val[i] || (exp_len[i] >= 0 && run_len[i] != exp_len[i])) begin
        errors++;
        $display("FAIL [%s] select_run_%0d: got sel=%h for %0d cycles, expected sel=%h for %0d cycles (-1 = any)",
                 tag, i, run_val[i], run_len[i], exp_val[i], exp_len[i]);
      end
    end
    $display("[%s] dump finished: %0d frames, to=%b ov=%b", tag, got_q.size(), o_timeout_flag, o_overflow_flag);
  endtask

  task automatic test_reset();
    i_reset      = 1'b0;
    i_dump_start = 1'b0;
    i_writing    = 1'b0;
    i_frame      = '0;
    i_tx_ready   = 1'b0;
    repeat (3) @(negedge i_clock);
    checks++;
    if (o_request_select !== IID) begin
      errors++;
      $display("FAIL [reset] select: got %h, expected %h", o_request_select, IID);
    end
    checks++;
    if (o_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL [reset] tx_valid: got %b, expected 0", o_tx_valid);
    end
    checks++;
    if (o_tx_data !== '0) begin
      errors++;
      $display("FAIL [reset] tx_data: got %h, expected 0", o_tx_data);
    end
    checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      errors++;
      $display("FAIL [reset] busy_done: got %b%b, expected 00", o_busy, o_done);
    end
    checks++;
    if ({o_timeout_flag, o_overflow_flag} !== 2'b00) begin
      errors++;
      $display("FAIL [reset] flags: got %b%b, expected 00", o_timeout_flag, o_overflow_flag);
    end
    i_reset = 1'b1;
    // Writing and ready activity without a start must leave the sequencer idle.
    for (int i = 0; i < 6; i++) begin
      i_writing  = 1'b1;
      i_tx_ready = 1'b1;
      i_frame    = $urandom();
      @(negedge i_clock);
      checks++;
      if ({o_request_select, o_busy, o_tx_valid} !== {IID, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL [reset] idle_ignore: got sel=%h busy=%b valid=%b, expected sel=%h busy=0 valid=0",
                 o_request_select, o_busy, o_tx_valid, IID);
      end
    end
    i_writing  = 1'b0;
    i_tx_ready = 1'b0;
    $display("[reset] reset and idle checks done");
  endtask

  task automatic test_basic();
    for (int c = 0; c < NC; c++) set_plan(c, 2, 1, NB'(32'hA0 + c));
    run_dump(0, 0, 0, -1, "basic");
  endtask

  task automatic test_timeout();
    for (int c = 0; c < NC; c++) set_plan(c, 2, 1, NB'(32'hA0 + c));
    set_plan(2, 0, 0, '0);
    run_dump(0, 0, 0, -1, "timeout");
  endtask

  task automatic test_overflow();
    for (int c = 0; c < NC; c++) set_plan(c, 1, 2, NB'(32'hB0 + 16 * c));
    set_plan(1, 1, 6, NB'(32'hC100));
    run_dump(0, 0, 0, -1, "overflow");
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < NC; c++) set_plan(c, $urandom_range(0, 5), 3, $urandom());
    run_dump(1, 1, 0, -1, "backpressure");
  endtask

  task automatic test_reset_mid_dump();
    random_plan();
    set_plan(0, 0, 0, '0);
    set_plan(1, 1, 6, $urandom());
    run_dump(2, 1, 0, 1, "abort");
    random_plan();
    run_dump(0, 0, 0, -1, "restart");
  endtask

  task automatic test_start_ignored();
    random_plan();
    run_dump(2, 1, 1, -1, "start_ignored");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      random_plan();
      run_dump($urandom_range(0, 2), 1, $urandom_range(0, 1) == 1, -1, $sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_backpressure();
    test_reset_mid_dump();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
